// File: rtl/flash_write.sv
// M25P16 write controller: WREN, sector erase, status poll, WREN, 1-byte page program, status poll.
// Optional poll timeout when FLASH_WR_TIMEOUT_EN is defined; otherwise polls indefinitely and err stays 0.
module flash_write #(
    parameter int unsigned GAP_CYC  = 8,
    parameter int unsigned POLL_MAX = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [23:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        trans_req,
    output logic [7:0]  tx_dout,
    input  logic [7:0]  rx_din,
    input  logic        trans_done,
    output logic        busy,
    output logic        done,
    output logic [7:0]  status,
    output logic        err
);
    localparam int unsigned GW = $clog2(GAP_CYC);

    if (GAP_CYC < 2) begin : g_gap_chk
        $error("GAP_CYC must be at least 2");
    end
    if (POLL_MAX < 1 || POLL_MAX > 65536) begin : g_poll_chk
        $error("POLL_MAX must fit the 16-bit poll counter");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_SE, S_PP, S_RDSR, S_CHK, S_GAP, S_DONE
    } state_e;

    state_e        state_q, state_d, nxt_q, nxt_d;
    logic          phase_q, phase_d;
    logic [2:0]    cnt_byte_q, cnt_byte_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [23:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          trans_req_q, trans_req_d;
    logic [7:0]    tx_dout_q, tx_dout_d;
    logic [7:0]    status_q, status_d;
`ifdef FLASH_WR_TIMEOUT_EN
    logic [15:0]   poll_q, poll_d;
    logic          err_q, err_d;
`endif

    function automatic logic [2:0] frame_last(input state_e s);
        case (s)
            S_SE:    frame_last = 3'd3;
            S_PP:    frame_last = 3'd4;
            S_RDSR:  frame_last = 3'd1;
            default: frame_last = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input state_e s, input logic [2:0] idx,
                                              input logic [23:0] a, input logic [7:0] d);
        frame_byte = 8'h00;
        case (s)
            S_WREN: frame_byte = 8'h06;
            S_SE, S_PP: begin
                case (idx)
                    3'd0:    frame_byte = (s == S_SE) ? 8'hD8 : 8'h02;
                    3'd1:    frame_byte = a[23:16];
                    3'd2:    frame_byte = a[15:8];
                    3'd3:    frame_byte = a[7:0];
                    default: frame_byte = d;
                endcase
            end
            S_RDSR:  frame_byte = (idx == 3'd0) ? 8'h05 : 8'h00;
            default: frame_byte = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            nxt_q       <= S_IDLE;
            phase_q     <= 1'b0;
            cnt_byte_q  <= '0;
            gap_cnt_q   <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            trans_req_q <= 1'b0;
            tx_dout_q   <= '0;
            status_q    <= '0;
`ifdef FLASH_WR_TIMEOUT_EN
            poll_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            phase_q     <= phase_d;
            cnt_byte_q  <= cnt_byte_d;
            gap_cnt_q   <= gap_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            trans_req_q <= trans_req_d;
            tx_dout_q   <= tx_dout_d;
            status_q    <= status_d;
`ifdef FLASH_WR_TIMEOUT_EN
            poll_q      <= poll_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        nxt_d       = nxt_q;
        phase_d     = phase_q;
        cnt_byte_d  = cnt_byte_q;
        gap_cnt_d   = gap_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        trans_req_d = trans_req_q;
        tx_dout_d   = tx_dout_q;
        status_d    = status_q;
`ifdef FLASH_WR_TIMEOUT_EN
        poll_d      = poll_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    state_d   = S_WREN;
                    phase_d   = 1'b0;
                    addr_d    = wr_addr;
                    data_d    = wr_data;
                    tx_dout_d = 8'h06;
`ifdef FLASH_WR_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            // First cycle in a command state raises CS#; tx_dout was loaded on entry.
            S_WREN, S_SE, S_PP, S_RDSR: begin
                if (!trans_req_q) begin
                    trans_req_d = 1'b1;
                end else if (trans_done) begin
                    if (cnt_byte_q == frame_last(state_q)) begin
                        cnt_byte_d  = '0;
                        trans_req_d = 1'b0;
                        gap_cnt_d   = '0;
                        case (state_q)
                            S_WREN: begin
                                state_d = S_GAP;
                                nxt_d   = phase_q ? S_PP : S_SE;
                            end
                            S_RDSR: begin
                                state_d  = S_CHK;
                                status_d = rx_din;
                            end
                            default: begin
                                state_d = S_GAP;
                                nxt_d   = S_RDSR;
`ifdef FLASH_WR_TIMEOUT_EN
                                poll_d  = '0;
`endif
                            end
                        endcase
                    end else begin
                        cnt_byte_d = cnt_byte_q + 3'd1;
                        tx_dout_d  = frame_byte(state_q, cnt_byte_q + 3'd1, addr_q, data_q);
                    end
                end
            end
            S_CHK: begin
                gap_cnt_d = '0;
                if (status_q[0]) begin
`ifdef FLASH_WR_TIMEOUT_EN
                    if (poll_q == 16'(POLL_MAX - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        poll_d  = poll_q + 16'd1;
                        state_d = S_GAP;
                        nxt_d   = S_RDSR;
                    end
`else
                    state_d = S_GAP;
                    nxt_d   = S_RDSR;
`endif
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    state_d = S_GAP;
                    nxt_d   = S_WREN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
                    state_d   = nxt_q;
                    gap_cnt_d = '0;
                    tx_dout_d = frame_byte(nxt_q, 3'd0, addr_q, data_q);
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trans_req = trans_req_q;
        tx_dout   = tx_dout_q;
        status    = status_q;
        busy      = !(state_q inside {S_IDLE, S_DONE});
        done      = (state_q == S_DONE);
`ifdef FLASH_WR_TIMEOUT_EN
        err       = err_q;
`else
        err       = 1'b0;
`endif
    end
endmodule
